// File: rtl/adder_seq_ctrl_pkg.sv
// rtl/adder_seq_ctrl_pkg.sv - state encoding and nibble width shared by the sequential adder
package adder_seq_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_seq_ctrl_adder_4bits.sv
// rtl/adder_seq_ctrl_adder_4bits.sv - combinational 4-bit ripple-carry adder for the nibble datapath
module adder_4bits
  import adder_seq_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[NIBBLE_W];
  end

endmodule

// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - WIDTH-bit add/sub sequenced over one nibble adder; ADDSEQ_SUB_EN enables subtract
module adder_seq_ctrl
  import adder_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t               state;
  state_t               state_nxt;
  logic [IDX_W-1:0]     idx;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [WIDTH-1:0]     s_shift;
  logic [WIDTH-1:0]     s_next;
  logic [WIDTH-1:0]     b_cap;
  logic                 c_cap;
  logic                 carry_reg;
  logic [NIBBLE_W-1:0]  nib_sum;
  logic                 nib_co;
  logic                 accept;
  logic                 last;

`ifdef ADDSEQ_SUB_EN
  // a - b == a + ~b + 1, so subtract forces the initial carry high
  assign b_cap = sub ? ~b : b;
  assign c_cap = sub | ci;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_cap      = b;
  assign c_cap      = ci;
`endif

  adder_4bits u_adder (
    .a  (a_reg[NIBBLE_W-1:0]),
    .b  (b_reg[NIBBLE_W-1:0]),
    .ci (carry_reg),
    .s  (nib_sum),
    .co (nib_co)
  );

  // Sum nibbles enter from the top so the LSB nibble lands at the bottom after NIBBLES shifts
  assign s_next = (s_shift >> NIBBLE_W) | (WIDTH'(nib_sum) << (WIDTH - NIBBLE_W));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = (idx == LAST_IDX);
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      s_shift   <= '0;
      carry_reg <= 1'b0;
      s         <= '0;
      co        <= 1'b0;
      ovf       <= 1'b0;
    end else if (accept) begin
      idx       <= '0;
      a_reg     <= a;
      b_reg     <= b_cap;
      carry_reg <= c_cap;
    end else if (state == RUN) begin
      idx       <= idx + IDX_W'(1);
      a_reg     <= a_reg >> NIBBLE_W;
      b_reg     <= b_reg >> NIBBLE_W;
      s_shift   <= s_next;
      carry_reg <= nib_co;
      if (last) begin
        s   <= s_next;
        co  <= nib_co;
        ovf <= (a_reg[NIBBLE_W-1] == b_reg[NIBBLE_W-1]) &&
               (nib_sum[NIBBLE_W-1] != a_reg[NIBBLE_W-1]);
      end
    end
  end

endmodule
